// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI message assembler: event encoding,
// status nibbles, SysEx/realtime byte values and the queued event record.
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CH_AT    = 3'd5,
    BEND     = 3'd6
  } evt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_D1,
    S_WAIT_D2,
    S_SYSEX
  } asm_state_t;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CH_AT    = 4'hD;
  localparam logic [3:0] ST_BEND     = 4'hE;

  localparam logic [7:0] SYX_START = 8'hF0;
  localparam logic [7:0] SYX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN    = 8'hF8;

  typedef struct packed {
    evt_t       etype;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
  } evt_s;

  // Note-on with velocity 0 is a note-off by MIDI convention.
  function automatic evt_t status_evt(input logic [3:0] st, input logic [6:0] d2);
    case (st)
      ST_NOTE_OFF: return NOTE_OFF;
      ST_NOTE_ON:  return (d2 == '0) ? NOTE_OFF : NOTE_ON;
      ST_POLY_AT:  return POLY_AT;
      ST_CC:       return CC;
      ST_PROG:     return PROG;
      ST_CH_AT:    return CH_AT;
      default:     return BEND;
    endcase
  endfunction

  function automatic logic one_data(input logic [3:0] st);
    return (st == ST_PROG) || (st == ST_CH_AT);
  endfunction

endpackage

// File: rtl/midi_evt_fifo.sv
// Synchronous event FIFO with a registered head and head-valid; the head
// holds its last value after the FIFO drains.
module midi_evt_fifo
  import midi_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type T = evt_s
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic head_valid,
  output T     head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T           mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, rd_nxt;
  T           head_q, head_d;
  logic       valid_q, valid_d;
  logic       empty, do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_q + PTR_ONE;

  // Head register is reloaded from the entry behind the popped one, or from
  // the incoming event when it becomes the only entry.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    head_d = head_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_nxt;
    if (do_pop) begin
      if (rd_nxt != wr_q)  head_d = mem_q[rd_nxt[AW-1:0]];
      else if (do_push)    head_d = din;
    end else if (empty && do_push) begin
      head_d = din;
    end
    valid_d = (wr_d != rd_d);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head_valid = valid_q;
  assign head       = head_q;

endmodule

// File: rtl/midi_msg_assembler.sv
// Assembles the CPU MIDI byte stream into channel-voice events with running
// status and queues them. Optional channel filter: define MIDI_CH_FILTER_EN.
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       byteready,
  input  logic [7:0] midi_in_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_type,
  output logic [3:0] evt_chan,
  output logic [6:0] evt_d1,
  output logic [6:0] evt_d2,
`ifdef MIDI_CH_FILTER_EN
  input  logic [3:0] rx_chan,
  input  logic       omni,
`endif
  output logic       ovf_sticky
);

  asm_state_t state_q, state_d;
  logic [7:0] run_status_q, run_status_d;
  logic [6:0] d1_q, d1_d;
  logic       br_q;
  logic       emit_q, emit_d;
  evt_s       evt_q, evt_d;
  logic       ovf_q, ovf_d;

  logic       accept, complete, chan_ok;
  logic [6:0] comp_d1, comp_d2;
  logic       fifo_full, pop;
  evt_s       head;

  assign accept = byteready & ~br_q;

`ifdef MIDI_CH_FILTER_EN
  assign chan_ok = omni | (run_status_q[3:0] == rx_chan);
`else
  assign chan_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    d1_d         = d1_q;
    complete     = 1'b0;
    comp_d1      = d1_q;
    comp_d2      = '0;
    if (accept && (midi_in_data < RT_MIN)) begin
      if (midi_in_data == SYX_START) begin
        state_d      = S_SYSEX;
        run_status_d = '0;
      end else if (midi_in_data[7]) begin
        // F1-F7 cancel running status; this also terminates SysEx.
        if (midi_in_data[7:4] != 4'hF) begin
          run_status_d = midi_in_data;
          state_d      = S_WAIT_D1;
        end else begin
          run_status_d = '0;
          state_d      = S_IDLE;
        end
      end else if ((state_q != S_SYSEX) && run_status_q[7]) begin
        if (state_q == S_WAIT_D2) begin
          complete = 1'b1;
          comp_d2  = midi_in_data[6:0];
          state_d  = S_WAIT_D1;
        end else begin
          d1_d    = midi_in_data[6:0];
          comp_d1 = midi_in_data[6:0];
          if (one_data(run_status_q[7:4])) begin
            complete = 1'b1;
            state_d  = S_WAIT_D1;
          end else begin
            state_d  = S_WAIT_D2;
          end
        end
      end
    end

    emit_d = complete & chan_ok;
    evt_d  = evt_q;
    if (complete) begin
      evt_d.etype = status_evt(run_status_q[7:4], comp_d2);
      evt_d.chan  = run_status_q[3:0];
      evt_d.d1    = comp_d1;
      evt_d.d2    = comp_d2;
    end
  end

  assign pop   = evt_valid & evt_ready;
  assign ovf_d = ovf_q | (emit_q & fifo_full & ~pop);

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= S_IDLE;
      run_status_q <= '0;
      d1_q         <= '0;
      br_q         <= 1'b0;
      emit_q       <= 1'b0;
      evt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      d1_q         <= d1_d;
      br_q         <= byteready;
      emit_q       <= emit_d;
      evt_q        <= evt_d;
      ovf_q        <= ovf_d;
    end
  end

  midi_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_s)
  ) u_fifo (
    .clk        (reg_clk),
    .rst_n      (reset_reg_N),
    .push       (emit_q),
    .din        (evt_q),
    .pop        (pop),
    .full       (fifo_full),
    .head_valid (evt_valid),
    .head       (head)
  );

  assign evt_type   = head.etype;
  assign evt_chan   = head.chan;
  assign evt_d1     = head.d1;
  assign evt_d2     = head.d2;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Directed bench for midi_msg_assembler (default build, FIFO_DEPTH=8).
module tb_midi_msg_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byteready = 1'b0;
  logic [7:0] midi_in_data = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_type;
  logic [3:0] evt_chan;
  logic [6:0] evt_d1, evt_d2;
  logic       ovf_sticky;

  int compared = 0;
  int mismatched = 0;

  midi_msg_assembler #(.FIFO_DEPTH(8)) dut (
    .reg_clk      (clk),
    .reset_reg_N  (rst_n),
    .byteready    (byteready),
    .midi_in_data (midi_in_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_type     (evt_type),
    .evt_chan     (evt_chan),
    .evt_d1       (evt_d1),
    .evt_d2       (evt_d2),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] ev(input int t, input int c, input int a, input int b);
    logic [21:0] r;
    r = {1'b1, t[2:0], c[3:0], a[6:0], b[6:0]};
    return r;
  endfunction

  function automatic logic [21:0] head();
    return {evt_valid, evt_type, evt_chan, evt_d1, evt_d2};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned hold);
    midi_in_data = b;
    byteready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 byteready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({head(), ovf_sticky} !== 23'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected 0", {head(), ovf_sticky});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_note_on();
    send_byte(8'h90, 1);
    send_byte(8'h3C, 1);
    midi_in_data = 8'h64;
    byteready = 1'b1;
    @(posedge clk); #1;
    byteready = 1'b0;
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL note_on_latency1: valid=%b expected 0", evt_valid);
    end
    @(posedge clk); #1;
    compared++;
    if (evt_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL note_on_latency2: valid=%b expected 1", evt_valid);
    end
    compared++;
    if (head() !== ev(1, 0, 'h3C, 'h64)) begin
      mismatched++;
      $display("FAIL note_on_event: got %h expected %h", head(), ev(1, 0, 'h3C, 'h64));
    end
    pop_one();
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL note_on_drain: valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_running_status();
    send_byte(8'h93, 1);
    send_byte(8'h40, 1);
    send_byte(8'h00, 1);
    send_byte(8'h41, 1);
    send_byte(8'h7F, 1);
    compared++;
    if (head() !== ev(0, 3, 'h40, 'h00)) begin
      mismatched++;
      $display("FAIL rs_note_off: got %h expected %h", head(), ev(0, 3, 'h40, 'h00));
    end
    pop_one();
    compared++;
    if (head() !== ev(1, 3, 'h41, 'h7F)) begin
      mismatched++;
      $display("FAIL rs_note_on: got %h expected %h", head(), ev(1, 3, 'h41, 'h7F));
    end
    pop_one();
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rs_drain: valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_realtime();
    send_byte(8'hB1, 1);
    send_byte(8'h07, 1);
    send_byte(8'hF8, 1);
    @(posedge clk); #1;
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rt_no_event: valid=%b expected 0", evt_valid);
    end
    send_byte(8'h64, 1);
    compared++;
    if (head() !== ev(3, 1, 'h07, 'h64)) begin
      mismatched++;
      $display("FAIL rt_cc: got %h expected %h", head(), ev(3, 1, 'h07, 'h64));
    end
    pop_one();
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rt_single: valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_sysex();
    send_byte(8'hF0, 1);
    send_byte(8'h7E, 1);
    send_byte(8'h01, 1);
    send_byte(8'hF7, 1);
    @(posedge clk); #1;
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL sysex_discard: valid=%b expected 0", evt_valid);
    end
    send_byte(8'hC2, 1);
    send_byte(8'h05, 1);
    compared++;
    if (head() !== ev(4, 2, 'h05, 'h00)) begin
      mismatched++;
      $display("FAIL sysex_prog: got %h expected %h", head(), ev(4, 2, 'h05, 'h00));
    end
    pop_one();
    send_byte(8'h06, 1);
    compared++;
    if (head() !== ev(4, 2, 'h06, 'h00)) begin
      mismatched++;
      $display("FAIL prog_running: got %h expected %h", head(), ev(4, 2, 'h06, 'h00));
    end
    pop_one();
  endtask

  task automatic test_bend_hold();
    send_byte(8'hE0, 3);
    send_byte(8'h00, 3);
    send_byte(8'h40, 3);
    compared++;
    if (head() !== ev(6, 0, 'h00, 'h40)) begin
      mismatched++;
      $display("FAIL bend_event: got %h expected %h", head(), ev(6, 0, 'h00, 'h40));
    end
    pop_one();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bend_single: valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    send_byte(8'h90, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        compared++;
        if (ovf_sticky !== 1'b0) begin
          mismatched++;
          $display("FAIL ovf_before_full: ovf=%b expected 0", ovf_sticky);
        end
      end
      send_byte(8'(8'h30 + i), 1);
      send_byte(8'h40, 1);
    end
    @(posedge clk); #1;
    compared++;
    if (ovf_sticky !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_set: ovf=%b expected 1", ovf_sticky);
    end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (head() !== ev(1, 0, 'h30 + i, 'h40)) begin
        mismatched++;
        $display("FAIL ovf_drain_%0d: got %h expected %h", i, head(), ev(1, 0, 'h30 + i, 'h40));
      end
      pop_one();
    end
    compared++;
    if ({evt_valid, ovf_sticky} !== 2'b01) begin
      mismatched++;
      $display("FAIL ovf_after_drain: valid/ovf=%b expected 01", {evt_valid, ovf_sticky});
    end
  endtask

  task automatic test_full_rw();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h92, 1);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h50 + i), 1);
      send_byte(8'h10, 1);
    end
    send_byte(8'h58, 1);
    midi_in_data = 8'h11;
    byteready = 1'b1;
    @(posedge clk); #1;
    byteready = 1'b0;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    compared++;
    if (ovf_sticky !== 1'b0) begin
      mismatched++;
      $display("FAIL full_rw_ovf: ovf=%b expected 0", ovf_sticky);
    end
    for (int i = 1; i < 9; i++) begin
      compared++;
      if (head() !== ev(1, 2, 'h50 + i, (i == 8) ? 'h11 : 'h10)) begin
        mismatched++;
        $display("FAIL full_rw_drain_%0d: got %h expected %h", i, head(),
                 ev(1, 2, 'h50 + i, (i == 8) ? 'h11 : 'h10));
      end
      pop_one();
    end
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL full_rw_empty: valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hC5, 1);
    send_byte(8'h10, 1);
    compared++;
    if (head() !== ev(4, 5, 'h10, 'h00)) begin
      mismatched++;
      $display("FAIL pre_reset_event: got %h expected %h", head(), ev(4, 5, 'h10, 'h00));
    end
    send_byte(8'h90, 1);
    send_byte(8'h3C, 1);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({head(), ovf_sticky} !== 23'd0) begin
      mismatched++;
      $display("FAIL async_reset: got %h expected 0", {head(), ovf_sticky});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h64, 1);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (evt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL partial_lost: valid=%b expected 0", evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_sysex();
    test_bend_hold();
    test_overflow();
    test_full_rw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
